// File: rtl/tipi_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tipi_bus_pkg
// Description : Shared types and constants for the TI-99/4A expansion-bus
//               initiator: command opcodes, FSM states, idle address value
//               and phase-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package tipi_bus_pkg;

    // Width of the per-phase down-counter (phases last 1..15 cycles)
    localparam int PHASE_CNT_W = 4;

    // Address bus value while no cycle is in progress
    localparam logic [15:0] TI_A_IDLE = 16'hFFFF;

    // Command opcodes as presented on cmd_op
    typedef enum logic [1:0] {
        OP_MEM_RD = 2'd0,
        OP_MEM_WR = 2'd1,
        OP_CRU_WR = 2'd2,
        OP_CRU_RD = 2'd3
    } cmd_op_e;

    // Bus-cycle sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } bus_state_e;

endpackage
`default_nettype wire

// File: rtl/ti_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : ti_bus_master
// Description : TI-99/4A expansion-bus initiator. Turns single commands into
//               memory or CRU bus cycles made of SETUP, STROBE and HOLD
//               phases and returns a one-cycle response. All outputs are
//               registered; bus values are computed from the next state.
// Revision    : 1.0 - initial release
// ============================================================================
module ti_bus_master
    import tipi_bus_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,

    output logic [15:0] ti_a,
    output logic        ti_memen,
    output logic        ti_we,
    output logic        ti_dbin,
    output logic        ti_cruclk,
    output logic        ti_ph3,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic [7:0]  d_in,
    input  logic        ti_cruin
);

    // Reject phase lengths the 4-bit counter cannot represent
    if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup_cyc
        $error("SETUP_CYC must be in 1..15");
    end
    if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe_cyc
        $error("STROBE_CYC must be in 1..15");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold_cyc
        $error("HOLD_CYC must be in 1..15");
    end

    // Counter reload values: the counter runs down to zero, so load length-1
    localparam logic [PHASE_CNT_W-1:0] c_setup_load  = PHASE_CNT_W'(SETUP_CYC - 1);
    localparam logic [PHASE_CNT_W-1:0] c_strobe_load = PHASE_CNT_W'(STROBE_CYC - 1);
    localparam logic [PHASE_CNT_W-1:0] c_hold_load   = PHASE_CNT_W'(HOLD_CYC - 1);

    bus_state_e               r_state;
    bus_state_e               w_state_nxt;
    logic [PHASE_CNT_W-1:0]   r_cnt;
    logic [PHASE_CNT_W-1:0]   w_cnt_nxt;

    cmd_op_e                  r_op;
    logic [15:0]              r_addr;
    logic [7:0]               r_wdata;
    logic [7:0]               r_cap;

    logic                     w_accept;
    logic                     w_done;
    logic                     w_strobe_last;
    cmd_op_e                  w_op_cur;
    logic [15:0]              w_addr_cur;
    logic [7:0]               w_wdata_cur;

    logic [15:0]              w_ti_a_nxt;
    logic                     w_ti_memen_nxt;
    logic                     w_ti_we_nxt;
    logic                     w_ti_dbin_nxt;
    logic                     w_ti_cruclk_nxt;
    logic                     w_ti_ph3_nxt;
    logic [7:0]               w_d_out_nxt;
    logic                     w_d_oe_nxt;

    assign w_accept      = (r_state == ST_IDLE) && cmd_valid;
    assign w_done        = (r_state == ST_HOLD) && (r_cnt == '0);
    assign w_strobe_last = (r_state == ST_STROBE) && (r_cnt == '0);

    // On the accept cycle the command registers are not loaded yet, so the
    // first SETUP bus values come straight from the command inputs.
    assign w_op_cur    = w_accept ? cmd_op_e'(cmd_op) : r_op;
    assign w_addr_cur  = w_accept ? cmd_addr          : r_addr;
    assign w_wdata_cur = w_accept ? cmd_wdata         : r_wdata;

    // Next-state and phase-counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = c_setup_load;
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_STROBE;
                    w_cnt_nxt   = c_strobe_load;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_STROBE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = c_hold_load;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Bus values for the state about to be entered (registered below)
    always_comb begin
        w_ti_a_nxt      = TI_A_IDLE;
        w_ti_memen_nxt  = 1'b1;
        w_ti_we_nxt     = 1'b1;
        w_ti_dbin_nxt   = 1'b0;
        w_ti_cruclk_nxt = 1'b0;
        w_ti_ph3_nxt    = 1'b0;
        w_d_out_nxt     = 8'h00;
        w_d_oe_nxt      = 1'b0;
        if (w_state_nxt != ST_IDLE) begin
            case (w_op_cur)
                OP_MEM_RD: begin
                    w_ti_a_nxt = w_addr_cur;
                    if (w_state_nxt != ST_HOLD) begin
                        w_ti_memen_nxt = 1'b0;
                        w_ti_dbin_nxt  = 1'b1;
                    end
                end
                OP_MEM_WR: begin
                    // Data stays driven through HOLD for hold time on the card
                    w_ti_a_nxt  = w_addr_cur;
                    w_d_oe_nxt  = 1'b1;
                    w_d_out_nxt = w_wdata_cur;
                    if (w_state_nxt != ST_HOLD) begin
                        w_ti_memen_nxt = 1'b0;
                    end
                    if (w_state_nxt == ST_STROBE) begin
                        w_ti_we_nxt = 1'b0;
                    end
                end
                OP_CRU_WR: begin
                    // A15 carries the CRU output bit
                    w_ti_a_nxt = {w_addr_cur[15:1], w_wdata_cur[0]};
                    if (w_state_nxt == ST_STROBE) begin
                        w_ti_cruclk_nxt = 1'b1;
                    end
                end
                OP_CRU_RD: begin
                    w_ti_a_nxt = {w_addr_cur[15:1], 1'b0};
                    if (w_state_nxt == ST_STROBE) begin
                        w_ti_ph3_nxt = 1'b1;
                    end
                end
                default: begin
                    w_ti_a_nxt = TI_A_IDLE;
                end
            endcase
        end
    end

    // Sequencer state, phase counter and latched command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_MEM_RD;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_op    <= w_op_cur;
                r_addr  <= w_addr_cur;
                r_wdata <= w_wdata_cur;
            end
        end
    end

    // Registered bus and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ti_a      <= TI_A_IDLE;
            ti_memen  <= 1'b1;
            ti_we     <= 1'b1;
            ti_dbin   <= 1'b0;
            ti_cruclk <= 1'b0;
            ti_ph3    <= 1'b0;
            d_out     <= 8'h00;
            d_oe      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            ti_a      <= w_ti_a_nxt;
            ti_memen  <= w_ti_memen_nxt;
            ti_we     <= w_ti_we_nxt;
            ti_dbin   <= w_ti_dbin_nxt;
            ti_cruclk <= w_ti_cruclk_nxt;
            ti_ph3    <= w_ti_ph3_nxt;
            d_out     <= w_d_out_nxt;
            d_oe      <= w_d_oe_nxt;
            cmd_ready <= (w_state_nxt == ST_IDLE);
        end
    end

    // Read-data capture on the final strobe cycle and response generation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap     <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
        end else begin
            if (w_strobe_last) begin
                case (r_op)
                    OP_MEM_RD: r_cap <= d_in;
                    OP_CRU_RD: r_cap <= {7'b0, ti_cruin};
                    default:   r_cap <= 8'h00;
                endcase
            end
            rsp_valid <= w_done;
            if (w_done) begin
                rsp_rdata <= r_cap;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ti_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ti_bus_master
// Description : Directed self-checking bench for ti_bus_master with default
//               phase lengths (SETUP 2, STROBE 3, HOLD 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ti_bus_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [15:0] ti_a;
    logic        ti_memen;
    logic        ti_we;
    logic        ti_dbin;
    logic        ti_cruclk;
    logic        ti_ph3;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [7:0]  d_in;
    logic        ti_cruin;

    int total;
    int bad;

    ti_bus_master u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ti_a      (ti_a),
        .ti_memen  (ti_memen),
        .ti_we     (ti_we),
        .ti_dbin   (ti_dbin),
        .ti_cruclk (ti_cruclk),
        .ti_ph3    (ti_ph3),
        .d_out     (d_out),
        .d_oe      (d_oe),
        .d_in      (d_in),
        .ti_cruin  (ti_cruin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a command at a falling edge; it is accepted at the next rising edge
    task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] wdata);
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        chk("accept_ready", {15'b0, cmd_ready}, 16'h0001);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_addr  = 16'h0000;
        cmd_wdata = 8'h00;
        d_in      = 8'h00;
        ti_cruin  = 1'b0;

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        chk("rst_ti_a",   ti_a,                16'hFFFF);
        chk("rst_memen",  {15'b0, ti_memen},   16'h0001);
        chk("rst_we",     {15'b0, ti_we},      16'h0001);
        chk("rst_dbin",   {15'b0, ti_dbin},    16'h0000);
        chk("rst_cruclk", {15'b0, ti_cruclk},  16'h0000);
        chk("rst_ph3",    {15'b0, ti_ph3},     16'h0000);
        chk("rst_d_oe",   {15'b0, d_oe},       16'h0000);
        chk("rst_ready",  {15'b0, cmd_ready},  16'h0001);
        chk("rst_rsp",    {15'b0, rsp_valid},  16'h0000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- MEM_RD 4000, d_in=A5 in STROBE ----------------
        issue(2'd0, 16'h4000, 8'h00);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            chk("rd_memen", {15'b0, ti_memen}, (k <= 5) ? 16'h0000 : 16'h0001);
            chk("rd_dbin",  {15'b0, ti_dbin},  (k <= 5) ? 16'h0001 : 16'h0000);
            chk("rd_ti_a",  ti_a,              (k <= 6) ? 16'h4000 : 16'hFFFF);
            chk("rd_d_oe",  {15'b0, d_oe},     16'h0000);
            chk("rd_rspv",  {15'b0, rsp_valid}, (k == 7) ? 16'h0001 : 16'h0000);
            chk("rd_ready", {15'b0, cmd_ready}, (k == 7) ? 16'h0001 : 16'h0000);
            if (k == 7) chk("rd_rdata", {8'h00, rsp_rdata}, 16'h00A5);
            if (k == 3) d_in = 8'hA5;
            if (k == 5) d_in = 8'hA5;
            if (k == 6) d_in = 8'h00;
        end
        @(negedge clk);
        chk("rd_rsp_pulse", {15'b0, rsp_valid}, 16'h0000);
        chk("rd_rdata_hold", {8'h00, rsp_rdata}, 16'h00A5);

        // ---------------- MEM_WR 3FFF <- 5A ----------------
        issue(2'd1, 16'h3FFF, 8'h5A);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            chk("wr_d_oe",  {15'b0, d_oe},  (k <= 6) ? 16'h0001 : 16'h0000);
            chk("wr_d_out", {8'h00, d_out}, (k <= 6) ? 16'h005A : 16'h0000);
            chk("wr_we",    {15'b0, ti_we}, (k >= 3 && k <= 5) ? 16'h0000 : 16'h0001);
            chk("wr_memen", {15'b0, ti_memen}, (k <= 5) ? 16'h0000 : 16'h0001);
            chk("wr_ti_a",  ti_a,           (k <= 6) ? 16'h3FFF : 16'hFFFF);
            chk("wr_dbin",  {15'b0, ti_dbin}, 16'h0000);
            chk("wr_rspv",  {15'b0, rsp_valid}, (k == 7) ? 16'h0001 : 16'h0000);
            if (k == 7) chk("wr_rdata", {8'h00, rsp_rdata}, 16'h0000);
        end

        // ---------------- CRU_WR 1102 bit 1 ----------------
        issue(2'd2, 16'h1102, 8'h01);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            chk("cw_ti_a",  ti_a, (k <= 6) ? 16'h1103 : 16'hFFFF);
            chk("cw_cruclk", {15'b0, ti_cruclk}, (k >= 3 && k <= 5) ? 16'h0001 : 16'h0000);
            chk("cw_memen", {15'b0, ti_memen}, 16'h0001);
            chk("cw_d_oe",  {15'b0, d_oe},     16'h0000);
            chk("cw_rspv",  {15'b0, rsp_valid}, (k == 7) ? 16'h0001 : 16'h0000);
            if (k == 7) chk("cw_rdata", {8'h00, rsp_rdata}, 16'h0000);
        end

        // ---------------- CRU_RD 1100, cruin=1 in STROBE ----------------
        issue(2'd3, 16'h1100, 8'h00);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            chk("cr_ti_a", ti_a, (k <= 6) ? 16'h1100 : 16'hFFFF);
            chk("cr_ph3",  {15'b0, ti_ph3}, (k >= 3 && k <= 5) ? 16'h0001 : 16'h0000);
            chk("cr_memen", {15'b0, ti_memen}, 16'h0001);
            chk("cr_cruclk", {15'b0, ti_cruclk}, 16'h0000);
            chk("cr_rspv", {15'b0, rsp_valid}, (k == 7) ? 16'h0001 : 16'h0000);
            if (k == 7) chk("cr_rdata", {8'h00, rsp_rdata}, 16'h0001);
            if (k == 3) ti_cruin = 1'b1;
            if (k == 6) ti_cruin = 1'b0;
        end

        // ---------------- abort: reset during STROBE of MEM_WR ----------------
        issue(2'd1, 16'h2000, 8'h77);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
        end
        chk("ab_pre_we", {15'b0, ti_we}, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ab_ti_a",  ti_a,              16'hFFFF);
        chk("ab_we",    {15'b0, ti_we},    16'h0001);
        chk("ab_memen", {15'b0, ti_memen}, 16'h0001);
        chk("ab_d_oe",  {15'b0, d_oe},     16'h0000);
        chk("ab_ready", {15'b0, cmd_ready}, 16'h0001);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("ab_no_rsp", {15'b0, rsp_valid}, 16'h0000);
            chk("ab_idle_a", ti_a, 16'hFFFF);
        end

        // ---------------- back-to-back MEM_RD with cmd_valid held ----------------
        d_in = 8'h3C;
        issue(2'd0, 16'h1234, 8'h00);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 8) cmd_valid = 1'b0;
            chk("bb_rspv",  {15'b0, rsp_valid}, (k == 7 || k == 14) ? 16'h0001 : 16'h0000);
            chk("bb_ready", {15'b0, cmd_ready}, (k == 7 || k == 14) ? 16'h0001 : 16'h0000);
            chk("bb_memen", {15'b0, ti_memen},
                ((k >= 1 && k <= 5) || (k >= 8 && k <= 12)) ? 16'h0000 : 16'h0001);
            if (k <= 6)              chk("bb_a1", ti_a, 16'h1234);
            if (k == 7)              chk("bb_gap_a", ti_a, 16'hFFFF);
            if (k >= 8 && k <= 13)   chk("bb_a2", ti_a, 16'h5678);
            if (k == 7 || k == 14)   chk("bb_rdata", {8'h00, rsp_rdata}, 16'h003C);
            // Second command is presented while the first is still in flight;
            // it must only be taken in the response cycle.
            if (k == 3) cmd_addr = 16'h5678;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
